// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two result sources, the arbiter and the register bank.
// master = the source/bank side, slave = the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic [4:0]    a_reg;
    logic [31:0]   a_data;
    logic          a_ready;
    logic          b_valid;
    logic [4:0]    b_reg;
    logic [31:0]   b_data;
    logic          b_ready;
    logic [4:0]    write_register;
    logic [31:0]   write_data;
    logic          RegWrite;
    logic [31:0]   pending;
    logic [CW-1:0] b_count;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready, write_register, write_data, RegWrite, pending, b_count
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready, write_register, write_data, RegWrite, pending, b_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-bank write port: ALU (A) has priority, load/muldiv (B) is FIFO-buffered
// and forced through after MAX_WAIT denials. ARB_STATS_EN adds stall_cnt/drop_cnt.
module regfile_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           drop_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {A_PRI, B_FORCE} state_t;

    state_t        state;
    logic [3:0]    wait_cnt;
    logic [4:0]    fifo_reg [DEPTH];
    logic [31:0]   fifo_dat [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic          grant_a;
    logic          grant_b;
    logic          push;
    logic          win;
    logic [4:0]    win_reg;
    logic [31:0]   win_dat;

    assign fifo_empty  = (count == '0);
    assign bus.a_ready = (state == A_PRI);
    assign bus.b_ready = (count != CW'(DEPTH));
    assign bus.b_count = count;

    assign grant_a = (state == A_PRI) && bus.a_valid;
    assign grant_b = !fifo_empty && ((state == B_FORCE) || !bus.a_valid);
    assign push    = bus.b_valid && bus.b_ready;
    assign win     = grant_a || grant_b;
    assign win_reg = grant_a ? bus.a_reg  : fifo_reg[rd_ptr];
    assign win_dat = grant_a ? bus.a_data : fifo_dat[rd_ptr];

    // Storage carries no reset: validity is defined purely by rd_ptr/count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr] <= bus.b_reg;
            fifo_dat[wr_ptr] <= bus.b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= A_PRI;
            wait_cnt           <= '0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            bus.write_register <= '0;
            bus.write_data     <= '0;
            bus.RegWrite       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (grant_b)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(grant_b);

            // Register 0 is consumed but never written.
            bus.RegWrite <= win && (win_reg != 5'd0);
            if (win) begin
                bus.write_register <= win_reg;
                bus.write_data     <= win_dat;
            end

            case (state)
                A_PRI: begin
                    if (fifo_empty || grant_b) begin
                        wait_cnt <= '0;
                    end else if (grant_a) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == 4'(MAX_WAIT - 1))
                            state <= B_FORCE;
                    end
                end
                B_FORCE: begin
                    wait_cnt <= '0;
                    state    <= A_PRI;
                end
                default: state <= A_PRI;
            endcase
        end
    end

    // Registers with a write in flight, derived from current FIFO and output-stage state.
    always_comb begin
        bus.pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count)
                bus.pending[fifo_reg[rd_ptr + PW'(k)]] = 1'b1;
        end
        if (bus.RegWrite)
            bus.pending[bus.write_register] = 1'b1;
        bus.pending[0] = 1'b0;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (bus.a_valid && !bus.a_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 1'b1;
            if (win && win_reg == 5'd0 && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized + directed bench: a queue-level reference model predicts grants, a monitor
// compares every bank write against the expected-write queue.
module tb_regfile_write_arbiter;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();
`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] drop_cnt;
`endif

    regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: B queue contents, consecutive-denial count, forced-grant flag.
    wr_t        mq[$];
    wr_t        expq[$];
    int         denied  = 0;
    bit         force_b = 0;
    logic [4:0] last_reg = 5'd0;
    int         stall_m = 0;
    int         drop_m  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic emit(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        if (r == 5'd0) begin
            drop_m++;
        end else begin
            w.r = r;
            w.d = d;
            expq.push_back(w);
            last_reg = r;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic bv, input logic [4:0] br, input logic [31:0] bd);
        logic [31:0] pend;
        bit          b_ok;
        wr_t         w;
        pend = '0;
        foreach (mq[i]) pend[mq[i].r] = 1'b1;
        if (last_reg != 5'd0) pend[last_reg] = 1'b1;
        pend[0] = 1'b0;
        chk("pending", 64'(bus.pending), 64'(pend));
        chk("b_count", 64'(bus.b_count), 64'(mq.size()));
        chk("a_ready", 64'(bus.a_ready), 64'(!force_b));
        chk("b_ready", 64'(bus.b_ready), 64'(mq.size() < DEPTH));

        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;

        b_ok     = (mq.size() < DEPTH);
        last_reg = 5'd0;
        if (av && force_b) stall_m++;
        if (av && !force_b) begin
            emit(ar, ad);
            if (mq.size() > 0) begin
                denied++;
                if (denied == MAX_WAIT) begin
                    force_b = 1;
                    denied  = 0;
                end
            end else begin
                denied = 0;
            end
        end else if (mq.size() > 0) begin
            w = mq.pop_front();
            emit(w.r, w.d);
            denied  = 0;
            force_b = 0;
        end else begin
            denied  = 0;
            force_b = 0;
        end
        if (bv && b_ok) begin
            w.r = br;
            w.d = bd;
            mq.push_back(w);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        denied = 0; force_b = 0; last_reg = 5'd0;
        stall_m = 0; drop_m = 0;
        chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_b_count",  64'(bus.b_count),  64'd0);
        chk("rst_pending",  64'(bus.pending),  64'd0);
        chk("rst_a_ready",  64'(bus.a_ready),  64'd1);
        chk("rst_b_ready",  64'(bus.b_ready),  64'd1);
    endtask

    // Monitor: every bank write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t w;
        if (bus.RegWrite === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", 64'(bus.write_register), 64'hFFFF);
            end else begin
                w = expq.pop_front();
                chk("write_register", 64'(bus.write_register), 64'(w.r));
                chk("write_data",     64'(bus.write_data),     64'(w.d));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Single A write and its one-cycle pending bit.
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
        chk("a_pending5", 64'(bus.pending[5]), 64'd1);
        idle(2);

        // A held valid: B reg 7 waits MAX_WAIT grants, then is forced through.
        step(1, 5'd1, 32'hA0, 1, 5'd7, 32'h11);
        for (int i = 0; i < 3; i++) step(1, 5'(2 + i), 32'hA1 + i, 0, 5'd0, 32'd0);
        chk("forced_a_ready", 64'(bus.a_ready), 64'd0);
        for (int i = 0; i < 3; i++) step(1, 5'(8 + i), 32'hB0 + i, 0, 5'd0, 32'd0);
        idle(3);

        // Fill the FIFO behind A, then a fifth push that must wait for the first pop.
        for (int i = 0; i < 4; i++) step(1, 5'(12 + i), 32'hC0 + i, 1, 5'(20 + i), 32'hD0 + i);
        chk("full_b_count", 64'(bus.b_count), 64'd4);
        chk("full_b_ready", 64'(bus.b_ready), 64'd0);
        for (int i = 0; i < 4; i++) step(1, 5'(16 + i), 32'hE0 + i, 1, 5'd25, 32'hF5);
        idle(8);

        // Reset with three queued entries and a staged write.
        for (int i = 0; i < 3; i++) step(1, 5'(3 + i), 32'h300 + i, 1, 5'(9 + i), 32'h900 + i);
        chk("pre_rst_b_count", 64'(bus.b_count), 64'd3);
        do_reset();

        // Writes to register 0 from both sources.
        step(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0);
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'h5678);
        idle(3);
`ifdef ARB_STATS_EN
        chk("drop_cnt_reg0", 64'(drop_cnt), 64'd2);
`endif

        for (int i = 0; i < 500; i++)
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
        idle(12);
        chk("drain_expq", 64'(expq.size()), 64'd0);
`ifdef ARB_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("drop_cnt",  64'(drop_cnt),  64'(drop_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
